// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore control FSM for a multicycle MIPS datapath,
// with an I/O wait-state handshake that times out after MAX_WAIT cycles.
module mips_multicycle_ctrl #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       IsIO,
    input  logic       IOReady,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCWrite,
    output logic       Branch,
    output logic       BusErr,
    output logic       IllegalOp,
    output logic [3:0] State
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEX   = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    state_t            state, nxt;
    logic [WAIT_W-1:0] cnt;
    logic [14:0]       ctrl;
    logic              in_mem, done, timeout, illegal;
    logic              unused_inputs;

    // Funct goes to the ALU decoder and Zero to the PC enable in the datapath
    assign unused_inputs = ^{Funct, Zero};

    // {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
    //  ALUSrcB, ALUOp, PCSrc, PCWrite, Branch}
    function automatic logic [14:0] decode(input state_t s);
        case (s)
            FETCH:    decode = 15'b0_0_1_0_0_0_0_01_00_00_1_0;
            DECODE:   decode = 15'b0_0_0_0_0_0_0_11_00_00_0_0;
            MEMADR:   decode = 15'b0_0_0_0_0_0_1_10_00_00_0_0;
            MEMREAD:  decode = 15'b1_0_0_0_0_0_0_00_00_00_0_0;
            MEMWB:    decode = 15'b0_0_0_0_1_1_0_00_00_00_0_0;
            MEMWRITE: decode = 15'b1_1_0_0_0_0_0_00_00_00_0_0;
            EXECUTE:  decode = 15'b0_0_0_0_0_0_1_00_10_00_0_0;
            ALUWB:    decode = 15'b0_0_0_1_0_1_0_00_00_00_0_0;
            BRANCH:   decode = 15'b0_0_0_0_0_0_1_00_01_01_0_1;
            ADDIEX:   decode = 15'b0_0_0_0_0_0_1_10_00_00_0_0;
            ADDIWB:   decode = 15'b0_0_0_0_0_1_0_00_00_00_0_0;
            JUMP:     decode = 15'b0_0_0_0_0_0_0_00_00_10_1_0;
            default:  decode = 15'b0;
        endcase
    endfunction

    always_comb begin
        nxt     = FETCH;
        illegal = 1'b0;
        in_mem  = (state == MEMREAD) || (state == MEMWRITE);
        done    = !IsIO || IOReady || (cnt == WAIT_W'(MAX_WAIT));
        // A ready device on the last allowed cycle wins over the timeout
        timeout = in_mem && IsIO && !IOReady && (cnt == WAIT_W'(MAX_WAIT));
        case (state)
            FETCH:    nxt = DECODE;
            DECODE: begin
                case (Op)
                    6'b100011, 6'b101011: nxt = MEMADR;
                    6'b000000:            nxt = EXECUTE;
                    6'b000100:            nxt = BRANCH;
                    6'b001000:            nxt = ADDIEX;
                    6'b000010:            nxt = JUMP;
                    default: begin
                        nxt     = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR:   nxt = (Op == 6'b100011) ? MEMREAD : MEMWRITE;
            MEMREAD:  nxt = done ? MEMWB : MEMREAD;
            MEMWRITE: nxt = done ? FETCH : MEMWRITE;
            EXECUTE:  nxt = ALUWB;
            ADDIEX:   nxt = ADDIWB;
            default:  nxt = FETCH;
        endcase
    end

    // Outputs are registered from the next state so they track state exactly
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= FETCH;
            cnt       <= '0;
            BusErr    <= 1'b0;
            IllegalOp <= 1'b0;
            ctrl      <= decode(FETCH);
        end else begin
            state     <= nxt;
            cnt       <= (in_mem && !done) ? cnt + 1'b1 : '0;
            BusErr    <= timeout;
            IllegalOp <= illegal;
            ctrl      <= decode(nxt);
        end
    end

    assign {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
            ALUSrcB, ALUOp, PCSrc, PCWrite, Branch} = ctrl;
    assign State = state;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: randomized scenario bench for the multicycle control
// FSM, checked against a per-instruction path model built from the state rules.
module tb_mips_multicycle_ctrl;
    localparam int MAX_WAIT = 15;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [5:0] Op = 6'd0, Funct = 6'd0;
    logic       Zero = 1'b0, IsIO = 1'b0, IOReady = 1'b0;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       PCWrite, Branch, BusErr, IllegalOp;
    logic [3:0] State;
    logic [14:0] got_ctrl;

    int n_cmp = 0, n_err = 0;
    logic [3:0] exp_s[$];
    logic [1:0] exp_p[$];
    int         memj[$];
    logic [5:0] cur_op;
    logic       cur_isio;
    int         cur_d;
    logic       carry_bus = 1'b0, carry_ill = 1'b0;

    mips_multicycle_ctrl #(.MAX_WAIT(MAX_WAIT), .WAIT_W(4)) dut (
        .CLK(CLK), .RESET(RESET), .Op(Op), .Funct(Funct), .Zero(Zero),
        .IsIO(IsIO), .IOReady(IOReady), .IorD(IorD), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSrc(PCSrc), .PCWrite(PCWrite), .Branch(Branch),
        .BusErr(BusErr), .IllegalOp(IllegalOp), .State(State)
    );

    always #5 CLK = ~CLK;

    assign got_ctrl = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                       ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite, Branch};

    // Which signals each state asserts, as membership sets
    function automatic logic [14:0] exp_ctrl(input logic [3:0] s);
        logic [1:0] srcb, aluop, pcsrc;
        srcb  = (s == 4'd0) ? 2'b01 : (s == 4'd1) ? 2'b11 :
                (s inside {4'd2, 4'd9}) ? 2'b10 : 2'b00;
        aluop = (s == 4'd6) ? 2'b10 : (s == 4'd8) ? 2'b01 : 2'b00;
        pcsrc = (s == 4'd8) ? 2'b01 : (s == 4'd11) ? 2'b10 : 2'b00;
        return {s inside {4'd3, 4'd5}, s == 4'd5, s == 4'd0, s == 4'd7, s == 4'd4,
                s inside {4'd4, 4'd7, 4'd10}, s inside {4'd2, 4'd6, 4'd8, 4'd9},
                srcb, aluop, pcsrc, s inside {4'd0, 4'd11}, s == 4'd8};
    endfunction

    task automatic push(input logic [3:0] s, input int j);
        exp_s.push_back(s);
        memj.push_back(j);
    endtask

    // Expected cycle-by-cycle state path of one instruction; d = wait cycles before IOReady
    task automatic plan(input logic [5:0] op, input logic isio, input int d);
        int   hold;
        logic tmo, ill;
        cur_op = op; cur_isio = isio; cur_d = d;
        Funct = 6'($urandom);
        hold = !isio ? 1 : (d <= MAX_WAIT ? d + 1 : MAX_WAIT + 1);
        tmo = isio && (d > MAX_WAIT);
        ill = 1'b0;
        exp_s.delete(); memj.delete(); exp_p.delete();
        push(4'd0, -1); push(4'd1, -1);
        case (op)
            6'b000000: begin push(4'd6, -1); push(4'd7, -1); end
            6'b100011: begin
                push(4'd2, -1);
                for (int j = 0; j < hold; j++) push(4'd3, j);
                push(4'd4, -1);
            end
            6'b101011: begin
                push(4'd2, -1);
                for (int j = 0; j < hold; j++) push(4'd5, j);
            end
            6'b000100: push(4'd8, -1);
            6'b001000: begin push(4'd9, -1); push(4'd10, -1); end
            6'b000010: push(4'd11, -1);
            default:   ill = 1'b1;
        endcase
        exp_p.push_back({carry_bus, carry_ill});
        for (int k = 1; k < exp_s.size(); k++)
            exp_p.push_back({tmo && (memj[k-1] == hold - 1), 1'b0});
        carry_bus = tmo && (memj[memj.size()-1] == hold - 1);
        carry_ill = ill;
    endtask

    task automatic drive(input int k);
        RESET = 1'b0;
        Op = cur_op;
        Zero = 1'($urandom);
        IsIO = (memj[k] >= 0) ? cur_isio : 1'($urandom);
        IOReady = (memj[k] >= 0) ? (memj[k] >= cur_d) : 1'($urandom);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        n_cmp++;
        if ({State, got_ctrl, BusErr, IllegalOp} !== {4'd0, exp_ctrl(4'd0), 2'b00}) begin
            n_err++;
            $display("FAIL reset: got st=%0d ctl=%h be=%b il=%b, expected st=0 ctl=%h pulses=00",
                     State, got_ctrl, BusErr, IllegalOp, exp_ctrl(4'd0));
        end
    endtask

    task automatic test_rtype();
        plan(6'b000000, 1'b0, 0);
        for (int k = 0; k < exp_s.size(); k++) begin
            @(negedge CLK);
            n_cmp++;
            if ({State, got_ctrl, BusErr, IllegalOp} !== {exp_s[k], exp_ctrl(exp_s[k]), exp_p[k]}) begin
                n_err++;
                $display("FAIL rtype k=%0d: got st=%0d ctl=%h pl=%b%b, expected st=%0d ctl=%h pl=%b",
                         k, State, got_ctrl, BusErr, IllegalOp, exp_s[k], exp_ctrl(exp_s[k]), exp_p[k]);
            end
            drive(k);
        end
    endtask

    task automatic test_lw_io_wait();
        int ds[3] = '{2, 15, 0};
        for (int i = 0; i < 3; i++) begin
            plan(6'b100011, 1'b1, ds[i]);
            for (int k = 0; k < exp_s.size(); k++) begin
                @(negedge CLK);
                n_cmp++;
                if ({State, got_ctrl, BusErr, IllegalOp} !== {exp_s[k], exp_ctrl(exp_s[k]), exp_p[k]}) begin
                    n_err++;
                    $display("FAIL lw_wait d=%0d k=%0d: got st=%0d ctl=%h pl=%b%b, expected st=%0d ctl=%h pl=%b",
                             ds[i], k, State, got_ctrl, BusErr, IllegalOp, exp_s[k], exp_ctrl(exp_s[k]), exp_p[k]);
                end
                drive(k);
            end
        end
    endtask

    task automatic test_timeout();
        logic [5:0] ops[2] = '{6'b101011, 6'b100011};
        for (int i = 0; i < 2; i++) begin
            plan(ops[i], 1'b1, 1000);
            for (int k = 0; k < exp_s.size(); k++) begin
                @(negedge CLK);
                n_cmp++;
                if ({State, got_ctrl, BusErr, IllegalOp} !== {exp_s[k], exp_ctrl(exp_s[k]), exp_p[k]}) begin
                    n_err++;
                    $display("FAIL timeout op=%b k=%0d: got st=%0d ctl=%h pl=%b%b, expected st=%0d ctl=%h pl=%b",
                             ops[i], k, State, got_ctrl, BusErr, IllegalOp, exp_s[k], exp_ctrl(exp_s[k]), exp_p[k]);
                end
                drive(k);
            end
        end
    endtask

    task automatic test_branch_jump();
        logic [5:0] ops[3] = '{6'b000100, 6'b000010, 6'b001000};
        for (int i = 0; i < 3; i++) begin
            plan(ops[i], 1'($urandom), 0);
            for (int k = 0; k < exp_s.size(); k++) begin
                @(negedge CLK);
                n_cmp++;
                if ({State, got_ctrl, BusErr, IllegalOp} !== {exp_s[k], exp_ctrl(exp_s[k]), exp_p[k]}) begin
                    n_err++;
                    $display("FAIL branch_jump op=%b k=%0d: got st=%0d ctl=%h pl=%b%b, expected st=%0d ctl=%h pl=%b",
                             ops[i], k, State, got_ctrl, BusErr, IllegalOp, exp_s[k], exp_ctrl(exp_s[k]), exp_p[k]);
                end
                drive(k);
            end
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ops[3] = '{6'b111111, 6'b000001, 6'b000000};
        for (int i = 0; i < 3; i++) begin
            plan(ops[i], 1'b0, 0);
            for (int k = 0; k < exp_s.size(); k++) begin
                @(negedge CLK);
                n_cmp++;
                if ({State, got_ctrl, BusErr, IllegalOp} !== {exp_s[k], exp_ctrl(exp_s[k]), exp_p[k]}) begin
                    n_err++;
                    $display("FAIL illegal op=%b k=%0d: got st=%0d ctl=%h pl=%b%b, expected st=%0d ctl=%h pl=%b",
                             ops[i], k, State, got_ctrl, BusErr, IllegalOp, exp_s[k], exp_ctrl(exp_s[k]), exp_p[k]);
                end
                drive(k);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        plan(6'b100011, 1'b1, 1000);
        for (int k = 0; k <= 8; k++) begin
            @(negedge CLK);
            n_cmp++;
            if ({State, got_ctrl, BusErr, IllegalOp} !== {exp_s[k], exp_ctrl(exp_s[k]), exp_p[k]}) begin
                n_err++;
                $display("FAIL reset_mid k=%0d: got st=%0d ctl=%h pl=%b%b, expected st=%0d ctl=%h pl=%b",
                         k, State, got_ctrl, BusErr, IllegalOp, exp_s[k], exp_ctrl(exp_s[k]), exp_p[k]);
            end
            drive(k);
        end
        RESET = 1'b1;
        carry_bus = 1'b0;
        carry_ill = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if ({State, got_ctrl, BusErr, IllegalOp} !== {4'd0, exp_ctrl(4'd0), 2'b00}) begin
            n_err++;
            $display("FAIL reset_mid_after: got st=%0d ctl=%h be=%b il=%b, expected st=0 ctl=%h pulses=00",
                     State, got_ctrl, BusErr, IllegalOp, exp_ctrl(4'd0));
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
        logic [5:0] op;
        for (int i = 0; i < 80; i++) begin
            op = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            plan(op, 1'($urandom), int'($urandom_range(0, 17)));
            for (int k = 0; k < exp_s.size(); k++) begin
                @(negedge CLK);
                n_cmp++;
                if ({State, got_ctrl, BusErr, IllegalOp} !== {exp_s[k], exp_ctrl(exp_s[k]), exp_p[k]}) begin
                    n_err++;
                    $display("FAIL back_to_back i=%0d op=%b d=%0d k=%0d: got st=%0d ctl=%h pl=%b%b, expected st=%0d ctl=%h pl=%b",
                             i, op, cur_d, k, State, got_ctrl, BusErr, IllegalOp, exp_s[k], exp_ctrl(exp_s[k]), exp_p[k]);
                end
                drive(k);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_io_wait();
        test_timeout();
        test_branch_jump();
        test_illegal();
        test_reset_mid_wait();
        test_timeout();
        test_back_to_back();
        test_rtype();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
